// File: rtl/pixel_block_gatherer_if.sv
// Pixel stream in, planar block out. The gatherer uses the slave view.
// m_pixels layout: channel k (3=r, 2=g, 1=b, 0=a) at [k*NUM_PIX*CH_W +: NUM_PIX*CH_W], pixel i at [i*CH_W +: CH_W].
interface pixel_block_gatherer_if #(
  parameter int NUM_PIX = 32,
  parameter int CH_W    = 8
);
  localparam int CNT_W = $clog2(NUM_PIX) + 1;

  logic                        s_valid;
  logic                        s_ready;
  logic [4*CH_W-1:0]           s_pixel;
  logic                        s_flush;
  logic                        m_valid;
  logic                        m_ready;
  logic [4*NUM_PIX*CH_W-1:0]   m_pixels;
  logic [CNT_W-1:0]            m_count;

  modport master (output s_valid, s_pixel, s_flush, m_ready,
                  input  s_ready, m_valid, m_pixels, m_count);
  modport slave  (input  s_valid, s_pixel, s_flush, m_ready,
                  output s_ready, m_valid, m_pixels, m_count);
endinterface

// File: rtl/pixel_block_gatherer.sv
// Ping-pong gatherer packing RGBA pixels into channel-planar blocks; flush closes and pads a partial block.
// Optional stall counter output enabled by defining GATHER_PERF_EN.
module pbg_slot #(
  parameter int PIX_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic             wr_bank,
  input  logic             rd_bank,
  input  logic [PIX_W-1:0] wr_data,
  output logic [PIX_W-1:0] rd_data
);
  logic [PIX_W-1:0] slot [2];

  always_ff @(posedge clk) begin
    if (!rst) begin
      slot[0] <= '0;
      slot[1] <= '0;
    end else if (wen) begin
      slot[wr_bank] <= wr_data;
    end
  end

  assign rd_data = slot[rd_bank];
endmodule

module pixel_block_gatherer #(
  parameter int NUM_PIX = 32,
  parameter int CH_W    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  pixel_block_gatherer_if.slave   bus
`ifdef GATHER_PERF_EN
  ,
  output logic [31:0]             stall_cycles
`endif
);
  localparam int IDX_W = $clog2(NUM_PIX);
  localparam int CNT_W = IDX_W + 1;
  localparam int PIX_W = 4 * CH_W;

  typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_st_t;

  bank_st_t          bank_st [2];
  bank_st_t          bank_st_nx [2];
  logic              wr_bank, rd_bank, wr_bank_nx, rd_bank_nx;
  logic [IDX_W-1:0]  wr_idx, wr_idx_nx;
  logic [PIX_W-1:0]  last_pix;
  logic [CNT_W-1:0]  cnt [2];

  logic              accept, close_acc, flush_only, closing, release_b;
  logic [CNT_W-1:0]  close_cnt;
  logic [PIX_W-1:0]  wr_data;
  logic [3:0][NUM_PIX-1:0][CH_W-1:0] pix_out;

  // s_ready depends only on registered state (and reset), never on m_ready
  assign bus.s_ready = rst && (bank_st[wr_bank] != FULL);
  assign accept      = bus.s_valid && bus.s_ready;
  assign close_acc   = accept && (bus.s_flush || wr_idx == IDX_W'(NUM_PIX - 1));
  // a standalone flush only closes a non-empty block; with s_valid high it waits for an accept
  assign flush_only  = bus.s_flush && !bus.s_valid && (wr_idx != '0);
  assign closing     = close_acc || flush_only;
  assign close_cnt   = {1'b0, wr_idx} + CNT_W'(accept);
  assign wr_data     = accept ? bus.s_pixel : last_pix;
  assign release_b   = bus.m_valid && bus.m_ready;

  always_comb begin
    bank_st_nx = bank_st;
    wr_bank_nx = wr_bank;
    rd_bank_nx = rd_bank;
    wr_idx_nx  = wr_idx;
    if (release_b) begin
      bank_st_nx[rd_bank] = EMPTY;
      rd_bank_nx          = ~rd_bank;
    end
    if (closing) begin
      bank_st_nx[wr_bank] = FULL;
      wr_bank_nx          = ~wr_bank;
      wr_idx_nx           = '0;
    end else if (accept) begin
      bank_st_nx[wr_bank] = FILLING;
      wr_idx_nx           = wr_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bank_st  <= '{EMPTY, EMPTY};
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      wr_idx   <= '0;
      last_pix <= '0;
      cnt      <= '{'0, '0};
    end else begin
      bank_st <= bank_st_nx;
      wr_bank <= wr_bank_nx;
      rd_bank <= rd_bank_nx;
      wr_idx  <= wr_idx_nx;
      if (accept)  last_pix     <= bus.s_pixel;
      if (closing) cnt[wr_bank] <= close_cnt;
    end
  end

  // slot j takes the pixel at wr_idx, or the pad value for every index past the close point
  for (genvar j = 0; j < NUM_PIX; j++) begin : g_slot
    logic             wen;
    logic [PIX_W-1:0] rd_data;

    assign wen = (accept && (wr_idx == IDX_W'(j) || (close_acc && wr_idx < IDX_W'(j))))
              || (flush_only && wr_idx <= IDX_W'(j));

    pbg_slot #(.PIX_W(PIX_W)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .wen     (wen),
      .wr_bank (wr_bank),
      .rd_bank (rd_bank),
      .wr_data (wr_data),
      .rd_data (rd_data)
    );

    for (genvar k = 0; k < 4; k++) begin : g_ch
      assign pix_out[k][j] = rd_data[k*CH_W +: CH_W];
    end
  end

  assign bus.m_pixels = pix_out;
  assign bus.m_valid  = (bank_st[rd_bank] == FULL);
  assign bus.m_count  = cnt[rd_bank];

`ifdef GATHER_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (bus.s_valid && !bus.s_ready && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif
endmodule
